// File: rtl/vga_pkg.sv
// Shared definitions for the VGA colour-bar generator and its pattern sequencer.
package vga_pkg;

    // 640x480 @ 60 Hz timing, in pixels / lines
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [2:0] {
        PAT_BARS    = 3'd0,
        PAT_GRAY    = 3'd1,
        PAT_RED     = 3'd2,
        PAT_GREEN   = 3'd3,
        PAT_BLUE    = 3'd4,
        PAT_CHECKER = 3'd5,
        PAT_INVERT  = 3'd6,
        PAT_BLACK   = 3'd7
    } pat_e;

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_APPLY = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    rise_q  <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/vga_pattern_ctrl.sv
// Steps the colour-bar generator through its patterns, committing changes only
// in vertical blanking; auto mode dwells N frames, manual mode advances on a button.
module vga_pattern_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS       = 8,
    parameter int unsigned FRAMES_PER_PATTERN = 60,
    parameter int unsigned DEBOUNCE_CYCLES    = 250000,
    parameter bit          VS_ACTIVE_LOW      = 1'b1,
    localparam int unsigned PW                = $clog2(NUM_PATTERNS)
) (
    input  logic          clock_25_i,
    input  logic          reset_n_i,
    input  logic          vga_vs_i,
    input  logic          btn_next_i,
    input  logic          btn_mode_i,
    output logic [PW-1:0] pattern_o,
    output logic          mode_auto_o,
    output logic          frame_start_o,
    output logic          pattern_update_o,
    output logic [15:0]   frame_cnt_o
);

    localparam int unsigned DW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

    ctrl_state_e   state_q, state_d;
    logic [PW-1:0] pattern_q, pattern_d;
    logic          mode_auto_q, mode_auto_d;
    logic          pattern_update_q, pattern_update_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          pending_q, pending_d;
    logic          frame_start_q;
    logic          vs_prev_q;
    logic          vs_active;
    logic          next_press;
    logic          mode_press;
    logic          expiry;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk_i  (clock_25_i),
        .rst_ni (reset_n_i),
        .btn_i  (btn_next_i),
        .rise_o (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_i  (clock_25_i),
        .rst_ni (reset_n_i),
        .btn_i  (btn_mode_i),
        .rise_o (mode_press)
    );

    // VS comes from the generator on this clock, so it is used unsynchronised
    assign vs_active = VS_ACTIVE_LOW ? ~vga_vs_i : vga_vs_i;

    always_ff @(posedge clock_25_i) begin
        if (!reset_n_i) begin
            state_q          <= S_WAIT;
            pattern_q        <= '0;
            mode_auto_q      <= 1'b1;
            pattern_update_q <= 1'b0;
            frame_cnt_q      <= '0;
            dwell_q          <= '0;
            pending_q        <= 1'b0;
            frame_start_q    <= 1'b0;
            vs_prev_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            pattern_q        <= pattern_d;
            mode_auto_q      <= mode_auto_d;
            pattern_update_q <= pattern_update_d;
            frame_cnt_q      <= frame_cnt_d;
            dwell_q          <= dwell_d;
            pending_q        <= pending_d;
            frame_start_q    <= vs_active & ~vs_prev_q;
            vs_prev_q        <= vs_active;
        end
    end

    // Later assignments to dwell_d/pending_d deliberately override earlier ones
    always_comb begin
        state_d          = state_q;
        pattern_d        = pattern_q;
        mode_auto_d      = mode_auto_q;
        pattern_update_d = 1'b0;
        frame_cnt_d      = frame_cnt_q;
        dwell_d          = dwell_q;
        pending_d        = pending_q;
        expiry           = 1'b0;

        if (frame_start_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (frame_start_q && mode_auto_q) begin
            expiry = (dwell_q == DW'(FRAMES_PER_PATTERN - 1)) && !mode_press;
            if (dwell_q != DW'(FRAMES_PER_PATTERN - 1)) begin
                dwell_d = dwell_q + DW'(1);
            end
        end

        if (mode_press) begin
            mode_auto_d = ~mode_auto_q;
            dwell_d     = '0;
        end

        if (next_press) begin
            pending_d = 1'b1;
            if (mode_auto_q) begin
                dwell_d = '0;
            end
        end

        case (state_q)
            S_WAIT: begin
                if (frame_start_q && (pending_q || next_press || expiry)) begin
                    state_d   = S_APPLY;
                    pending_d = 1'b0;
                    dwell_d   = '0;
                end
            end
            S_APPLY: begin
                pattern_d        = (pattern_q == PW'(NUM_PATTERNS - 1)) ? '0 : pattern_q + PW'(1);
                pattern_update_d = 1'b1;
                state_d          = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign pattern_o        = pattern_q;
    assign mode_auto_o      = mode_auto_q;
    assign frame_start_o    = frame_start_q;
    assign pattern_update_o = pattern_update_q;
    assign frame_cnt_o      = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Scoreboard bench for vga_pattern_ctrl with small simulation parameters.
module tb_vga_pattern_ctrl;

    localparam int unsigned NP  = 5;
    localparam int unsigned FPP = 3;
    localparam int unsigned DEB = 4;
    localparam int unsigned PW  = 3;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          vs        = 1'b1;
    logic          btn_next  = 1'b0;
    logic          btn_mode  = 1'b0;
    logic [PW-1:0] pattern;
    logic          mode_auto;
    logic          frame_start;
    logic          pattern_update;
    logic [15:0]   frame_cnt;

    vga_pattern_ctrl #(
        .NUM_PATTERNS       (NP),
        .FRAMES_PER_PATTERN (FPP),
        .DEBOUNCE_CYCLES    (DEB),
        .VS_ACTIVE_LOW      (1'b1)
    ) dut (
        .clock_25_i       (clk),
        .reset_n_i        (reset_n),
        .vga_vs_i         (vs),
        .btn_next_i       (btn_next),
        .btn_mode_i       (btn_mode),
        .pattern_o        (pattern),
        .mode_auto_o      (mode_auto),
        .frame_start_o    (frame_start),
        .pattern_update_o (pattern_update),
        .frame_cnt_o      (frame_cnt)
    );

    always #20 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] pat;
        int unsigned   cyc;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   fs_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [PW-1:0] model_pat = '0;

    function automatic logic [PW-1:0] next_pat(input logic [PW-1:0] p);
        return (p == PW'(NP - 1)) ? '0 : p + PW'(1);
    endfunction

    // Scoreboard: pattern updates and frame-start pulses against pushed expectations
    always @(negedge clk) begin
        if (pattern_update) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_update: got pattern=%0d at cyc %0d, required no update", pattern, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pattern !== e.pat || cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL pattern_update: got pattern=%0d cyc=%0d, required pattern=%0d cyc=%0d",
                             pattern, cyc, e.pat, e.cyc);
                end
            end
        end
        if (frame_start) begin
            n_cmp++;
            if (fs_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_frame_start: got pulse at cyc %0d, required none", cyc);
            end else begin
                int unsigned c;
                c = fs_q.pop_front();
                if (cyc !== c) begin
                    n_err++;
                    $display("FAIL frame_start_timing: got cyc=%0d, required cyc=%0d", cyc, c);
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        model_pat = '0;
    endtask

    // Drive VS active at this negedge; expectations are queued with the stimulus
    task automatic vs_start(input bit adv);
        exp_t e;
        @(negedge clk);
        fs_q.push_back(cyc + 1);
        if (adv) begin
            model_pat = next_pat(model_pat);
            e.pat = model_pat;
            e.cyc = cyc + 3;
            exp_q.push_back(e);
        end
        vs = 1'b0;
    endtask

    task automatic do_frame(input bit adv);
        vs_start(adv);
        repeat (3) @(negedge clk);
        vs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic press(input bit is_mode);
        @(negedge clk);
        if (is_mode) btn_mode = 1'b1; else btn_next = 1'b1;
        repeat (6) @(negedge clk);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (pattern !== 3'd0) begin n_err++; $display("FAIL reset_pattern: got %0d, required 0", pattern); end
        n_cmp++; if (mode_auto !== 1'b1) begin n_err++; $display("FAIL reset_mode_auto: got %b, required 1", mode_auto); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start: got %b, required 0", frame_start); end
        n_cmp++; if (pattern_update !== 1'b0) begin n_err++; $display("FAIL reset_update: got %b, required 0", pattern_update); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt); end
        reset_n   = 1'b1;
        model_pat = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_auto_first();
        for (int f = 1; f <= 7; f++) do_frame((f % FPP) == 0);
        n_cmp++; if (pattern !== model_pat) begin n_err++; $display("FAIL auto7_pattern: got %0d, required %0d", pattern, model_pat); end
        n_cmp++; if (frame_cnt !== 16'd7) begin n_err++; $display("FAIL auto7_frame_cnt: got %0d, required 7", frame_cnt); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL auto7_missing_updates: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_auto_wrap();
        reset_dut();
        for (int f = 1; f <= 15; f++) do_frame((f % FPP) == 0);
        n_cmp++; if (pattern !== 3'd0) begin n_err++; $display("FAIL wrap_pattern: got %0d, required 0", pattern); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_missing_updates: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_mode();
        press(1'b1);
        n_cmp++; if (mode_auto !== 1'b0) begin n_err++; $display("FAIL mode_toggle: got %b, required 0", mode_auto); end
        for (int f = 0; f < 10; f++) do_frame(1'b0);
        n_cmp++; if (pattern !== 3'd0) begin n_err++; $display("FAIL manual_hold: got %0d, required 0", pattern); end
        n_cmp++; if (frame_cnt !== 16'd25) begin n_err++; $display("FAIL manual_frame_cnt: got %0d, required 25", frame_cnt); end
    endtask

    task automatic test_manual_next();
        for (int i = 0; i < 3; i++) press(1'b0);
        do_frame(1'b1);
        do_frame(1'b0);
        n_cmp++; if (pattern !== 3'd1) begin n_err++; $display("FAIL triple_press: got %0d, required 1", pattern); end
        @(negedge clk);
        btn_next = 1'b1;
        repeat (2) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        do_frame(1'b0);
        n_cmp++; if (pattern !== model_pat) begin n_err++; $display("FAIL glitch_reject: got %0d, required %0d", pattern, model_pat); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL manual_missing_updates: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        // NEXT press whose pulse lands on the FRAME_START cycle
        @(negedge clk);
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        vs_start(1'b1);
        @(negedge clk);
        btn_next = 1'b0;
        repeat (2) @(negedge clk);
        vs = 1'b1;
        repeat (12) @(negedge clk);
        do_frame(1'b0);
        n_cmp++; if (pattern !== 3'd2) begin n_err++; $display("FAIL press_on_frame_start: got %0d, required 2", pattern); end
        // Pending advance, plus a press landing in the apply cycle
        press(1'b0);
        @(negedge clk);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        vs_start(1'b1);
        repeat (2) @(negedge clk);
        btn_next = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        repeat (10) @(negedge clk);
        do_frame(1'b1);
        do_frame(1'b0);
        n_cmp++; if (pattern !== 3'd4) begin n_err++; $display("FAIL press_in_apply: got %0d, required 4", pattern); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing_updates: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_apply();
        press(1'b0);
        do_frame(1'b1);
        press(1'b0);
        do_frame(1'b1);
        n_cmp++; if (pattern !== 3'd1) begin n_err++; $display("FAIL pre_reset_pattern: got %0d, required 1", pattern); end
        press(1'b0);
        @(negedge clk);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        vs_start(1'b0);
        repeat (2) @(negedge clk);
        btn_next = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        n_cmp++; if (pattern !== 3'd0) begin n_err++; $display("FAIL midreset_pattern: got %0d, required 0", pattern); end
        n_cmp++; if (pattern_update !== 1'b0) begin n_err++; $display("FAIL midreset_update: got %b, required 0", pattern_update); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL midreset_frame_cnt: got %0d, required 0", frame_cnt); end
        n_cmp++; if (mode_auto !== 1'b1) begin n_err++; $display("FAIL midreset_mode_auto: got %b, required 1", mode_auto); end
        vs = 1'b1;
        @(negedge clk);
        reset_n   = 1'b1;
        model_pat = '0;
        repeat (5) @(negedge clk);
        do_frame(1'b0);
        n_cmp++; if (pattern !== 3'd0) begin n_err++; $display("FAIL pending_dropped: got %0d, required 0", pattern); end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL post_reset_frame_cnt: got %0d, required 1", frame_cnt); end
        n_cmp++; if (exp_q.size() != 0 || fs_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queues: got %0d/%0d left, required 0/0", exp_q.size(), fs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_auto_first();
        test_auto_wrap();
        test_mode();
        test_manual_next();
        test_back_to_back();
        test_reset_mid_apply();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
